// File: rtl/price_pkg.sv
// Shared definitions for the price lookup path.
//   PRODUCT_CODE_W / PRICE_W / CREDIT_W : field widths
//   DEFAULT_PRICE                       : reset value of each table entry (code + 1)
//   state_t                             : lookup sequencer states
//   change_amount()                     : gated change computation
package price_pkg;

    localparam int PRODUCT_CODE_W = 3;
    localparam int PRICE_W        = 4;
    localparam int CREDIT_W       = 8;
    localparam int MAX_PRODUCTS   = 8;

    // Packed so that DEFAULT_PRICE[i] is the reset price of product i.
    localparam logic [MAX_PRODUCTS-1:0][PRICE_W-1:0] DEFAULT_PRICE = {
        4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Change is only meaningful when the credit covers the price; otherwise 0,
    // so the subtraction can never wrap.
    function automatic logic [CREDIT_W-1:0] change_amount(
        input logic [CREDIT_W-1:0] cr,
        input logic [PRICE_W-1:0]  p,
        input logic                ok
    );
        logic [CREDIT_W-1:0] p_ext;
        p_ext = {{(CREDIT_W-PRICE_W){1'b0}}, p};
        return ok ? (cr - p_ext) : '0;
    endfunction

endpackage

// File: rtl/price_table.sv
// Per-product price register file.
//   clock, resetN : clock and asynchronous active-low reset (entries revert to defaults)
//   wr_en, wr_code, wr_price : write port; out-of-range codes are ignored
//   rd_code       : combinational read address
//   rd_price      : entry value (0 when rd_code is out of range)
//   rd_in_range   : rd_code addresses a real product
// Optional feature macro: PRICE_WRITE_BYPASS_EN -- when defined, a write to the
// code being read in the same cycle is forwarded to rd_price.
module price_table
    import price_pkg::*;
#(
    parameter int NUM_PRODUCTS = 6
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      wr_en,
    input  logic [PRODUCT_CODE_W-1:0] wr_code,
    input  logic [PRICE_W-1:0]        wr_price,
    input  logic [PRODUCT_CODE_W-1:0] rd_code,
    output logic [PRICE_W-1:0]        rd_price,
    output logic                      rd_in_range
);

    localparam logic [PRODUCT_CODE_W:0] NUM_P = (PRODUCT_CODE_W+1)'(NUM_PRODUCTS);

    logic [NUM_PRODUCTS-1:0][PRICE_W-1:0] entry;
    logic                                 wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_code} < NUM_P);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            entry <= DEFAULT_PRICE[NUM_PRODUCTS-1:0];
        end else if (wr_ok) begin
            entry[wr_code] <= wr_price;
        end
    end

    always_comb begin
        rd_in_range = ({1'b0, rd_code} < NUM_P);
        rd_price    = '0;
        if (rd_in_range) begin
            rd_price = entry[rd_code];
        end
`ifdef PRICE_WRITE_BYPASS_EN
        if (rd_in_range && wr_ok && (wr_code == rd_code)) begin
            rd_price = wr_price;
        end
`endif
    end

endmodule

// File: rtl/price_read_module.sv
// Price lookup server between the price-change writer and the vending FSM.
//   clock, resetN          : clock, asynchronous active-low reset
//   wrEn, wrCode, wrPrice  : table write port (accepted in every state)
//   readReq, readCode, credit : lookup request, sampled only in IDLE
//   readAck                : consumer accepts the response (HOLD only)
//   busy, readValid        : lookup in progress / response valid
//   price, readErr, affordable, change : registered response snapshot
// Optional feature macro: PRICE_WRITE_BYPASS_EN (see price_table) -- a write
// to the latched code during FETCH is reflected in the response.
module price_read_module
    import price_pkg::*;
#(
    parameter int NUM_PRODUCTS = 6
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      wrEn,
    input  logic [PRODUCT_CODE_W-1:0] wrCode,
    input  logic [PRICE_W-1:0]        wrPrice,
    input  logic                      readReq,
    input  logic [PRODUCT_CODE_W-1:0] readCode,
    input  logic [CREDIT_W-1:0]       credit,
    input  logic                      readAck,
    output logic                      busy,
    output logic                      readValid,
    output logic [PRICE_W-1:0]        price,
    output logic                      readErr,
    output logic                      affordable,
    output logic [CREDIT_W-1:0]       change
);

    state_t                    state;
    logic [PRODUCT_CODE_W-1:0] code_p0;
    logic [CREDIT_W-1:0]       credit_p0;
    logic [PRICE_W-1:0]        tbl_price;
    logic                      tbl_in_range;
    logic                      can_afford;

    price_table #(
        .NUM_PRODUCTS (NUM_PRODUCTS)
    ) u_table (
        .clock       (clock),
        .resetN      (resetN),
        .wr_en       (wrEn),
        .wr_code     (wrCode),
        .wr_price    (wrPrice),
        .rd_code     (code_p0),
        .rd_price    (tbl_price),
        .rd_in_range (tbl_in_range)
    );

    // An out-of-range code reads as price 0, so it must be excluded explicitly.
    assign can_afford = tbl_in_range &&
                        (credit_p0 >= {{(CREDIT_W-PRICE_W){1'b0}}, tbl_price});

    // Stage p0: request capture (data only, no reset needed)
    always_ff @(posedge clock) begin
        if ((state == IDLE) && readReq) begin
            code_p0   <= readCode;
            credit_p0 <= credit;
        end
    end

    // Stage p1: sequencer and registered response snapshot
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            busy       <= 1'b0;
            readValid  <= 1'b0;
            price      <= '0;
            readErr    <= 1'b0;
            affordable <= 1'b0;
            change     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (readReq) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    state      <= HOLD;
                    readValid  <= 1'b1;
                    price      <= tbl_price;
                    readErr    <= !tbl_in_range;
                    affordable <= can_afford;
                    change     <= change_amount(credit_p0, tbl_price, can_afford);
                end
                HOLD: begin
                    if (readAck) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        readValid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    readValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_price_read_module.sv
module tb_price_read_module;

    localparam int NUMP = 6;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       wrEn = 1'b0;
    logic [2:0] wrCode = '0;
    logic [3:0] wrPrice = '0;
    logic       readReq = 1'b0;
    logic [2:0] readCode = '0;
    logic [7:0] credit = '0;
    logic       readAck = 1'b0;
    logic       busy, readValid, readErr, affordable;
    logic [3:0] price;
    logic [7:0] change;

    int n_checks = 0;
    int n_err = 0;

    price_read_module #(.NUM_PRODUCTS(NUMP)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .wrEn       (wrEn),
        .wrCode     (wrCode),
        .wrPrice    (wrPrice),
        .readReq    (readReq),
        .readCode   (readCode),
        .credit     (credit),
        .readAck    (readAck),
        .busy       (busy),
        .readValid  (readValid),
        .price      (price),
        .readErr    (readErr),
        .affordable (affordable),
        .change     (change)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Table of prices, plus "edges since the lookup was accepted"
    // (0 = no lookup, 1 = fetching, 2 = response presented).
    int m_tbl[8];
    int m_age;
    int m_code, m_credit;
    int m_price, m_err, m_aff, m_chg;
    bit m_fresh;
    bit cmp_en = 1'b0;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_tbl[i] = i + 1;
        m_age = 0;
        m_price = 0; m_err = 0; m_aff = 0; m_chg = 0;
        m_fresh = 1'b1;
    endfunction

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            model_reset();
        end else begin
            int p;
            bit in_range;
            if (m_age == 0) begin
                if (readReq) begin
                    m_code = int'(readCode);
                    m_credit = int'(credit);
                    m_age = 1;
                end
            end else if (m_age == 1) begin
                in_range = (m_code < NUMP);
                p = in_range ? m_tbl[m_code] : 0;
`ifdef PRICE_WRITE_BYPASS_EN
                if (in_range && wrEn && int'(wrCode) == m_code) p = int'(wrPrice);
`endif
                m_price = p;
                m_err = in_range ? 0 : 1;
                m_aff = (in_range && m_credit >= p) ? 1 : 0;
                m_chg = m_aff ? (m_credit - p) : 0;
                m_fresh = 1'b0;
                m_age = 2;
            end else if (readAck) begin
                m_age = 0;
            end
            if (wrEn && int'(wrCode) < NUMP) m_tbl[wrCode] = int'(wrPrice);
        end
    end

    // Compare process: every falling edge, away from the active edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("busy", int'(busy), (m_age != 0) ? 1 : 0);
            check("readValid", int'(readValid), (m_age == 2) ? 1 : 0);
            if (m_age == 2 || m_fresh) begin
                check("price", int'(price), m_price);
                check("readErr", int'(readErr), m_err);
                check("affordable", int'(affordable), m_aff);
                check("change", int'(change), m_chg);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic write_price(input int c, input int p);
        wrEn = 1'b1; wrCode = 3'(c); wrPrice = 4'(p);
        step();
        wrEn = 1'b0;
    endtask

    int cap_price, cap_err, cap_aff, cap_chg;

    task automatic do_read(input int c, input int cr, input int hold,
                           input bit wr_fetch, input int wc, input int wp,
                           input bit extra_req);
        readReq = 1'b1; readCode = 3'(c); credit = 8'(cr);
        step();                          // request sampled, now fetching
        readReq = 1'b0;
        if (wr_fetch) begin
            wrEn = 1'b1; wrCode = 3'(wc); wrPrice = 4'(wp);
        end
        step();                          // response registered
        wrEn = 1'b0;
        check("latency_valid", int'(readValid), 1);
        cap_price = int'(price); cap_err = int'(readErr);
        cap_aff = int'(affordable); cap_chg = int'(change);
        for (int i = 0; i < hold; i++) begin
            if (extra_req) begin
                readReq = 1'b1; readCode = 3'd0; credit = 8'd200;
            end
            step();
        end
        readReq = 1'b0;
        if (hold > 0) begin
            check("hold_valid", int'(readValid), 1);
            check("hold_price_stable", int'(price), cap_price);
        end
        readAck = 1'b1;
        step();
        readAck = 1'b0;
        check("ack_drops_valid", int'(readValid), 0);
    endtask

    initial begin
        model_reset();
        step();
        step();
        cmp_en = 1'b1;
        // Reset state
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(readValid), 0);
        check("rst_price", int'(price), 0);
        check("rst_change", int'(change), 0);
        resetN = 1'b1;
        step();

        // Default table: code 4 -> 5
        do_read(4, 10, 0, 1'b0, 0, 0, 1'b0);
        check("r4_price", cap_price, 5);
        check("r4_aff", cap_aff, 1);
        check("r4_change", cap_chg, 5);
        check("r4_err", cap_err, 0);

        write_price(4, 2);
        do_read(4, 1, 0, 1'b0, 0, 0, 1'b0);
        check("w4_price", cap_price, 2);
        check("w4_aff", cap_aff, 0);
        check("w4_change", cap_chg, 0);

        do_read(7, 50, 0, 1'b0, 0, 0, 1'b0);
        check("r7_price", cap_price, 0);
        check("r7_err", cap_err, 1);
        check("r7_aff", cap_aff, 0);

        write_price(6, 9);
        do_read(0, 5, 0, 1'b0, 0, 0, 1'b0);
        check("r0_price", cap_price, 1);
        check("r0_change", cap_chg, 4);

        // Write during FETCH to the code being fetched, then hold 5 cycles
        do_read(3, 20, 5, 1'b1, 3, 12, 1'b1);
`ifdef PRICE_WRITE_BYPASS_EN
        check("bypass_price", cap_price, 12);
        check("bypass_change", cap_chg, 8);
`else
        check("nobypass_price", cap_price, 4);
        check("nobypass_change", cap_chg, 16);
`endif
        check("extra_req_ignored_busy", int'(busy), 0);

        // Reset in the middle of a HOLD
        write_price(2, 15);
        readReq = 1'b1; readCode = 3'd1; credit = 8'd9;
        step();
        readReq = 1'b0;
        step();
        check("pre_rst_valid", int'(readValid), 1);
        resetN = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_valid", int'(readValid), 0);
        check("arst_price", int'(price), 0);
        check("arst_err", int'(readErr), 0);
        check("arst_aff", int'(affordable), 0);
        check("arst_change", int'(change), 0);
        step();
        step();
        resetN = 1'b1;
        step();
        do_read(2, 3, 0, 1'b0, 0, 0, 1'b0);
        check("post_rst_r2_price", cap_price, 3);
        check("post_rst_r2_aff", cap_aff, 1);
        check("post_rst_r2_change", cap_chg, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            wrEn     = ($urandom_range(0, 3) == 0);
            wrCode   = 3'($urandom_range(0, 7));
            wrPrice  = 4'($urandom_range(0, 15));
            readReq  = ($urandom_range(0, 1) == 1);
            readCode = 3'($urandom_range(0, 7));
            credit   = 8'($urandom_range(0, 24));
            readAck  = ($urandom_range(0, 2) != 0);
            step();
        end
        wrEn = 1'b0; readReq = 1'b0; readAck = 1'b1;
        step();
        step();
        readAck = 1'b0;
        step();
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
